// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH single-bit storage cells sharing one clock and one
// run-time mode (D, T, SR, JK). Adds sticky per-channel flags for the illegal
// SR input, a saturating count of cycles where any output changed, and a
// global enable. No handshake: every enabled rising edge is a transaction.
module multi_mode_ff_bank #(
   parameter int               WIDTH      = 4,
   parameter logic [WIDTH-1:0] INIT       = '0,
   parameter int               SR_ILLEGAL = 0,
   parameter int               CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] err,
   output logic [CNT_W-1:0] chg_cnt,
   output logic             any_err
);

   typedef enum logic [1:0] {
      MODE_D  = 2'b00,
      MODE_T  = 2'b01,
      MODE_SR = 2'b10,
      MODE_JK = 2'b11
   } mode_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mode_t            mode_sel;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] err_set;
   logic             changed;

   assign mode_sel = mode_t'(mode);

   // Per-channel next state and illegal-SR detection; disabled cycles hold.
   always_comb begin
      q_next  = q;
      err_set = '0;
      if (en) begin
         for (int i = 0; i < WIDTH; i++) begin
            case (mode_sel)
               MODE_D: q_next[i] = a[i];
               MODE_T: q_next[i] = q[i] ^ a[i];
               MODE_SR: begin
                  case ({a[i], b[i]})
                     2'b01: q_next[i] = 1'b0;
                     2'b10: q_next[i] = 1'b1;
                     2'b11: begin
                        err_set[i] = 1'b1;
                        if (SR_ILLEGAL == 1)      q_next[i] = 1'b1;
                        else if (SR_ILLEGAL == 2) q_next[i] = 1'b0;
                        else if (SR_ILLEGAL == 3) q_next[i] = ~q[i];
                        else                      q_next[i] = q[i];
                     end
                     default: q_next[i] = q[i];
                  endcase
               end
               MODE_JK: begin
                  case ({a[i], b[i]})
                     2'b01:   q_next[i] = 1'b0;
                     2'b10:   q_next[i] = 1'b1;
                     2'b11:   q_next[i] = ~q[i];
                     default: q_next[i] = q[i];
                  endcase
               end
               default: q_next[i] = q[i];
            endcase
         end
      end
   end

   // q_next equals q whenever en is low, so this is already gated by enable.
   assign changed = (q_next != q);

   // Storage register for the channel outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= INIT;
      else      q <= q_next;
   end

   // Sticky error flags; a new illegal event beats a clear on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         err <= '0;
      else if (err_clr) err <= err_set;
      else              err <= err | err_set;
   end

   // Saturating change counter; clear takes priority over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             chg_cnt <= '0;
      else if (cnt_clr)                     chg_cnt <= '0;
      else if (changed && chg_cnt != CNT_MAX) chg_cnt <= chg_cnt + CNT_ONE;
   end

   assign qbar    = ~q;
   assign any_err = |err;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Bench for multi_mode_ff_bank: four instances (SR_ILLEGAL 0..3) share one
// stimulus stream. The driver pushes expected {q, err, chg_cnt} per instance
// into a queue on the falling edge; each test pops and compares after the
// following rising edge.
module tb_multi_mode_ff_bank;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [3:0] a;
   logic [3:0] b;
   logic       err_clr;
   logic       cnt_clr;

   logic [3:0] q_o    [4];
   logic [3:0] qbar_o [4];
   logic [3:0] err_o  [4];
   logic [2:0] cnt_o  [4];
   logic       any_o  [4];

   // Reference state per instance.
   logic [3:0] m_q   [4];
   logic [3:0] m_err [4];
   logic [2:0] m_cnt [4];

   logic [10:0] exp_q[$];
   int          n_checks;
   int          n_fail;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      multi_mode_ff_bank #(
         .WIDTH(4), .INIT(4'b0101), .SR_ILLEGAL(g), .CNT_W(3)
      ) u_dut (
         .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
         .err_clr(err_clr), .cnt_clr(cnt_clr),
         .q(q_o[g]), .qbar(qbar_o[g]), .err(err_o[g]),
         .chg_cnt(cnt_o[g]), .any_err(any_o[g])
      );
   end

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int g = 0; g < 4; g++) begin
         m_q[g]   = 4'b0101;
         m_err[g] = 4'b0000;
         m_cnt[g] = 3'd0;
      end
      exp_q.delete();
   endtask

   // Driver: applies inputs on the falling edge and pushes expectations.
   task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] av,
                        input logic [3:0] bv, input logic ec, input logic cc);
      logic [3:0] nq;
      logic [3:0] set;
      @(negedge clk);
      en = e; mode = m; a = av; b = bv; err_clr = ec; cnt_clr = cc;
      for (int g = 0; g < 4; g++) begin
         nq  = m_q[g];
         set = 4'b0000;
         if (e) begin
            for (int i = 0; i < 4; i++) begin
               if (m == 2'b00) nq[i] = av[i];
               else if (m == 2'b01) nq[i] = m_q[g][i] ^ av[i];
               else if (av[i] && !bv[i]) nq[i] = 1'b1;
               else if (!av[i] && bv[i]) nq[i] = 1'b0;
               else if (av[i] && bv[i]) begin
                  if (m == 2'b11) nq[i] = ~m_q[g][i];
                  else begin
                     set[i] = 1'b1;
                     if (g == 1) nq[i] = 1'b1;
                     else if (g == 2) nq[i] = 1'b0;
                     else if (g == 3) nq[i] = ~m_q[g][i];
                  end
               end
            end
         end
         if (cc) m_cnt[g] = 3'd0;
         else if (nq != m_q[g] && m_cnt[g] != 3'd7) m_cnt[g] = m_cnt[g] + 3'd1;
         m_err[g] = ec ? set : (m_err[g] | set);
         m_q[g]   = nq;
         exp_q.push_back({m_q[g], m_err[g], m_cnt[g]});
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; mode = 2'b01; a = 4'b1111; b = 4'b1111;
      err_clr = 1'b0; cnt_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      for (int g = 0; g < 4; g++) begin
         n_checks++;
         if (q_o[g] !== 4'b0101 || qbar_o[g] !== 4'b1010 || err_o[g] !== 4'b0000 ||
             cnt_o[g] !== 3'd0 || any_o[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset inst%0d: got q=%b qbar=%b err=%b cnt=%0d any=%b, expected 0101 1010 0000 0 0",
                     g, q_o[g], qbar_o[g], err_o[g], cnt_o[g], any_o[g]);
         end
      end
      @(negedge clk);
      en = 1'b0; mode = 2'b00; a = 4'b0000; b = 4'b0000;
      rst = 1'b1;
   endtask

   task automatic test_d_t();
      logic [10:0] exp_v;
      logic [3:0]  want [3];
      want[0] = 4'b1100; want[1] = 4'b1010; want[2] = 4'b1100;
      for (int s = 0; s < 3; s++) begin
         if (s == 0) drive(1'b1, 2'b00, 4'b1100, 4'b0000, 1'b0, 1'b0);
         else        drive(1'b1, 2'b01, 4'b0110, 4'b0000, 1'b0, 1'b0);
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            n_checks++;
            exp_v = exp_q.pop_front();
            if ({q_o[g], err_o[g], cnt_o[g]} !== exp_v || qbar_o[g] !== ~exp_v[10:7] ||
                any_o[g] !== (|exp_v[6:3])) begin
               n_fail++;
               $display("FAIL d_t inst%0d step%0d: got q=%b err=%b cnt=%0d, expected q=%b err=%b cnt=%0d",
                        g, s, q_o[g], err_o[g], cnt_o[g], exp_v[10:7], exp_v[6:3], exp_v[2:0]);
            end
         end
         n_checks++;
         if (q_o[0] !== want[s]) begin
            n_fail++;
            $display("FAIL d_t_q step%0d: got %b, expected %b", s, q_o[0], want[s]);
         end
      end
      n_checks++;
      if (cnt_o[0] !== 3'd3) begin
         n_fail++;
         $display("FAIL d_t_cnt: got %0d, expected 3", cnt_o[0]);
      end
   endtask

   task automatic test_sr_illegal();
      logic [10:0] exp_v;
      logic [3:0]  want_q [3][4];
      logic [3:0]  want_err [3];
      // From q=1100: ch0 set, ch1 illegal, ch2 reset, ch3 hold.
      want_q[0][0] = 4'b1001; want_q[0][1] = 4'b1011; want_q[0][2] = 4'b1001; want_q[0][3] = 4'b1011;
      want_q[1][0] = 4'b1001; want_q[1][1] = 4'b1011; want_q[1][2] = 4'b1001; want_q[1][3] = 4'b1001;
      want_q[2][0] = 4'b1001; want_q[2][1] = 4'b1011; want_q[2][2] = 4'b1001; want_q[2][3] = 4'b1001;
      want_err[0] = 4'b0010; want_err[1] = 4'b0010; want_err[2] = 4'b0000;
      for (int s = 0; s < 3; s++) begin
         if (s == 0)      drive(1'b1, 2'b10, 4'b0011, 4'b0110, 1'b0, 1'b0);
         else if (s == 1) drive(1'b1, 2'b10, 4'b0011, 4'b0110, 1'b1, 1'b0);
         else             drive(1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1, 1'b0);
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            n_checks++;
            exp_v = exp_q.pop_front();
            if ({q_o[g], err_o[g], cnt_o[g]} !== exp_v || qbar_o[g] !== ~exp_v[10:7] ||
                any_o[g] !== (|exp_v[6:3])) begin
               n_fail++;
               $display("FAIL sr inst%0d step%0d: got q=%b err=%b cnt=%0d, expected q=%b err=%b cnt=%0d",
                        g, s, q_o[g], err_o[g], cnt_o[g], exp_v[10:7], exp_v[6:3], exp_v[2:0]);
            end
            n_checks++;
            if (q_o[g] !== want_q[s][g] || err_o[g] !== want_err[s] ||
                any_o[g] !== (want_err[s] != 4'b0000)) begin
               n_fail++;
               $display("FAIL sr_const inst%0d step%0d: got q=%b err=%b any=%b, expected q=%b err=%b",
                        g, s, q_o[g], err_o[g], any_o[g], want_q[s][g], want_err[s]);
            end
         end
      end
   endtask

   task automatic test_jk();
      logic [10:0] exp_v;
      logic [3:0]  prev [4];
      for (int s = 0; s < 2; s++) begin
         for (int g = 0; g < 4; g++) prev[g] = q_o[g];
         drive(1'b1, 2'b11, 4'b1111, 4'b1111, 1'b0, 1'b0);
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            n_checks++;
            exp_v = exp_q.pop_front();
            if ({q_o[g], err_o[g], cnt_o[g]} !== exp_v || qbar_o[g] !== ~exp_v[10:7] ||
                any_o[g] !== (|exp_v[6:3])) begin
               n_fail++;
               $display("FAIL jk inst%0d step%0d: got q=%b err=%b cnt=%0d, expected q=%b err=%b cnt=%0d",
                        g, s, q_o[g], err_o[g], cnt_o[g], exp_v[10:7], exp_v[6:3], exp_v[2:0]);
            end
            n_checks++;
            if (q_o[g] !== ~prev[g] || err_o[g] !== 4'b0000) begin
               n_fail++;
               $display("FAIL jk_toggle inst%0d: got q=%b err=%b, expected q=%b err=0000",
                        g, q_o[g], err_o[g], ~prev[g]);
            end
         end
      end
   endtask

   task automatic test_enable_sat();
      logic [10:0] exp_v;
      for (int s = 0; s < 13; s++) begin
         if (s < 3)       drive(1'b0, 2'b01, 4'b1111, 4'b0000, 1'b0, 1'b0);
         else if (s < 12) drive(1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0, 1'b0);
         else             drive(1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0, 1'b1);
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            n_checks++;
            exp_v = exp_q.pop_front();
            if ({q_o[g], err_o[g], cnt_o[g]} !== exp_v || qbar_o[g] !== ~exp_v[10:7] ||
                any_o[g] !== (|exp_v[6:3])) begin
               n_fail++;
               $display("FAIL en_sat inst%0d step%0d: got q=%b err=%b cnt=%0d, expected q=%b err=%b cnt=%0d",
                        g, s, q_o[g], err_o[g], cnt_o[g], exp_v[10:7], exp_v[6:3], exp_v[2:0]);
            end
         end
         if (s == 11) begin
            n_checks++;
            if (cnt_o[0] !== 3'd7) begin
               n_fail++;
               $display("FAIL sat_cnt: got %0d, expected 7", cnt_o[0]);
            end
         end
         if (s == 12) begin
            n_checks++;
            if (cnt_o[0] !== 3'd0) begin
               n_fail++;
               $display("FAIL cnt_clr_prio: got %0d, expected 0", cnt_o[0]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp_v;
      for (int s = 0; s < 60; s++) begin
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            n_checks++;
            exp_v = exp_q.pop_front();
            if ({q_o[g], err_o[g], cnt_o[g]} !== exp_v || qbar_o[g] !== ~exp_v[10:7] ||
                any_o[g] !== (|exp_v[6:3])) begin
               n_fail++;
               $display("FAIL b2b inst%0d step%0d: got q=%b err=%b cnt=%0d, expected q=%b err=%b cnt=%0d",
                        g, s, q_o[g], err_o[g], cnt_o[g], exp_v[10:7], exp_v[6:3], exp_v[2:0]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [10:0] exp_v;
      // Leave some error and count state behind before the reset hits.
      drive(1'b1, 2'b10, 4'b1111, 4'b1111, 1'b0, 1'b0);
      @(posedge clk); #1;
      exp_q.delete();
      #2;
      rst = 1'b0;
      #1;
      for (int g = 0; g < 4; g++) begin
         n_checks++;
         if (q_o[g] !== 4'b0101 || qbar_o[g] !== 4'b1010 || err_o[g] !== 4'b0000 ||
             cnt_o[g] !== 3'd0 || any_o[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset inst%0d: got q=%b qbar=%b err=%b cnt=%0d any=%b, expected 0101 1010 0000 0 0",
                     g, q_o[g], qbar_o[g], err_o[g], cnt_o[g], any_o[g]);
         end
      end
      en = 1'b1; mode = 2'b01; a = 4'b1111; b = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
         n_checks++;
         if (q_o[g] !== 4'b0101 || cnt_o[g] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_hold inst%0d: got q=%b cnt=%0d, expected 0101 0", g, q_o[g], cnt_o[g]);
         end
      end
      @(negedge clk);
      en = 1'b0;
      rst = 1'b1;
      model_reset();
      // First edge after release behaves normally.
      drive(1'b1, 2'b00, 4'b1010, 4'b0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
         n_checks++;
         exp_v = exp_q.pop_front();
         if ({q_o[g], err_o[g], cnt_o[g]} !== exp_v || q_o[g] !== 4'b1010 || cnt_o[g] !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset inst%0d: got q=%b err=%b cnt=%0d, expected q=1010 err=0000 cnt=1",
                     g, q_o[g], err_o[g], cnt_o[g]);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_d_t();
      test_sr_illegal();
      test_jk();
      test_enable_sat();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_mode_ff_bank.md
# multi_mode_ff_bank

Parametrised bank of WIDTH single-bit storage elements sharing one clock. All channels share one run-time mode: D, T, SR or JK. This generalises the single-bit SR-from-JK cell into a reusable multi-channel register. It adds three things:
- configurable handling of the illegal SR input (S=R=1), with sticky per-channel error flags;
- a saturating counter of cycles in which any output changed;
- a global enable.

It sits wherever the design needs a small bank of behaviourally-selectable flip-flops.

## Interface
Parameters:
- WIDTH, 4, number of channels (1..32)
- INIT, 0 (WIDTH bits), q value loaded on reset
- SR_ILLEGAL, 0, SR-mode response to S=R=1: 0 hold, 1 force 1, 2 force 0, 3 toggle
- CNT_W, 8, width of change counter (2..16)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; 0 = all state holds
- mode  in  2  00 D, 01 T, 10 SR, 11 JK
- a  in  WIDTH  per-channel first input: D / T / S / J
- b  in  WIDTH  per-channel second input: unused in D/T; R / K
- err_clr  in  1  clears all err bits
- cnt_clr  in  1  clears chg_cnt
- q  out  WIDTH  stored state
- qbar  out  WIDTH  always ~q (combinational from q)
- err  out  WIDTH  sticky per-channel illegal-SR flag
- chg_cnt  out  CNT_W  saturating count of enabled cycles with q change
- any_err  out  1  OR-reduction of err

## Operation
- Reset (rst=0, any time, independent of clk): q=INIT, qbar=~INIT, err=0, chg_cnt=0, any_err=0. Release is synchronous-safe; the first update is on the first rising edge with rst=1.
- en=0: q, err and chg_cnt hold. err_clr and cnt_clr still act.
- Next state per channel i when en=1 (a=a[i], b=b[i]):
  - D: q=a.
  - T: q=q^a.
  - SR, (a,b)=00: hold.
  - SR, 01: 0.
  - SR, 10: 1.
  - SR, 11: per SR_ILLEGAL, and err[i] set.
  - JK, 00: hold.
  - JK, 01: 0.
  - JK, 10: 1.
  - JK, 11: toggle. Never sets err.
- mode is sampled on the same edge as a/b. A mode change mid-stream takes effect on that edge, with no pipeline flush or bubble.
- Error flags:
  - err[i] sets only in SR mode with a[i]=b[i]=1 and en=1.
  - err_clr=1 clears all bits on the edge.
  - err_clr and a new illegal event on the same edge: the set wins for that channel; other channels clear.
- Change counter:
  - chg_cnt increments by 1 on an enabled edge where next q != current q (any bit).
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 forces 0 and takes priority over an increment on the same edge.
- Arithmetic: the counter is unsigned CNT_W bits. The saturation compare uses all-ones of CNT_W.

## Timing
- Latency: inputs sampled at edge N appear on q, err and chg_cnt after edge N. qbar and any_err follow q and err combinationally within the same cycle.
- No handshakes. Every enabled edge is a transaction.
- Inputs must be stable around the rising edge. The bench drives inputs on the falling edge.
- Reset mid-operation: asynchronous assertion immediately forces the reset values. Inputs present while rst=0 have no effect.

## Test plan
Parameters: WIDTH=4, INIT=4'b0101, SR_ILLEGAL=0, CNT_W=3, unless noted.

1. Reset:
   - Stimulus: assert rst=0 mid-cycle after arbitrary activity.
   - Required: q=0101, qbar=1010, err=0, chg_cnt=0 immediately, before any clock edge.
2. D and T modes:
   - Stimulus: mode=00, a=1100 for one edge; then mode=01, a=0110 for two edges.
   - Required: q=1100, then 1010, then 1100; chg_cnt=3.
3. SR mode with illegal input:
   - Stimulus: mode=10, (a,b)=(0011,0110).
   - Required: ch0 S → 1; ch1 S=R=1 → hold and err[1]=1; ch2 R → 0; ch3 hold; any_err=1.
   - Stimulus: err_clr with repeated (a,b) on the next edge.
   - Required: err[1] stays 1 (set wins). With a=b=0 and err_clr on the edge after, err=0000.
4. SR_ILLEGAL variants and JK toggle:
   - Stimulus: rerun scenario 3 with SR_ILLEGAL=1, 2, then 3.
   - Required: ch1 goes to 1, 0, then ~q respectively.
   - Stimulus: mode=11, a=b=1111 for two edges.
   - Required: q toggles each edge, err unchanged.
5. Enable and counter saturation:
   - Stimulus: en=0 with mode=01, a=1111.
   - Required: q and chg_cnt hold.
   - Stimulus: en=1 for 9 toggle edges.
   - Required: chg_cnt saturates at 7.
   - Stimulus: cnt_clr on the same edge as a change.
   - Required: chg_cnt=0.
